// File: rtl/mx_dot_acc.sv
// Pipelined minifloat dot-product accumulator: exact lane products, cross-lane sum, per-block accumulation.
// Optional MX_DOT_ACC_SAT_EN: saturate the accumulator at signed acc_width bounds and report it on o_ovf.
module mx_dot_acc #(
    parameter int exp_width = 3,
    parameter int man_width = 2,
    parameter int lanes     = 4,
    parameter int block_len = 8,
    parameter int acc_width = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    input  logic [lanes*(1+exp_width+man_width)-1:0]   i_op0,
    input  logic [lanes*(1+exp_width+man_width)-1:0]   i_op1,
    input  logic                                       i_last,
    output logic                                       o_valid,
    input  logic                                       i_out_ready,
    output logic signed [acc_width-1:0]                o_acc,
    output logic [$clog2(block_len+1)-1:0]             o_len,
    output logic                                       o_ovf
);
    localparam int ELEM_W = 1 + exp_width + man_width;
    localparam int MAG_W  = (1 << exp_width) + man_width - 1;
    localparam int PRD_W  = 2 * ((1 << exp_width) + man_width + 2);
    localparam int SUM_W  = PRD_W + $clog2(lanes);
    localparam int CNT_W  = $clog2(block_len + 1);

    // Element {s, e, m} to signed integer: subnormal-like m for e==0, else {1,m} << (e-1).
    function automatic logic signed [PRD_W-1:0] elem_int(input logic [ELEM_W-1:0] x);
        logic [exp_width-1:0]     e;
        logic [man_width-1:0]     m;
        logic [MAG_W-1:0]         mag;
        logic signed [PRD_W-1:0]  v;
        e = x[ELEM_W-2 -: exp_width];
        m = x[man_width-1:0];
        if (e == '0) mag = MAG_W'(m);
        else         mag = MAG_W'({1'b1, m}) << (e - exp_width'(1));
        v = PRD_W'(mag);
        return x[ELEM_W-1] ? -v : v;
    endfunction

    logic                    stall;
    logic                    accept;
    logic signed [PRD_W-1:0] prod    [lanes];
    logic                    s1_valid;
    logic                    s1_last;
    logic signed [PRD_W-1:0] s1_prod [lanes];
    logic signed [SUM_W-1:0] lane_sum;
    logic signed [acc_width-1:0] acc;
    logic signed [acc_width-1:0] acc_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    close;
    logic                    beat_go;

    assign stall   = o_valid && !i_out_ready;
    assign o_ready = !stall;
    assign accept  = i_valid && o_ready;
    assign beat_go = s1_valid && !stall;

    always_comb begin
        for (int k = 0; k < lanes; k++) begin
            prod[k] = elem_int(i_op0[k*ELEM_W +: ELEM_W]) * elem_int(i_op1[k*ELEM_W +: ELEM_W]);
        end
    end

    // Stage 1: control bits hold under stall so the beat is replayed once the result drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s1_last  <= i_last;
        end
    end

    // NOTE: product registers carry no reset; s1_valid qualifies them, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < lanes; k++) s1_prod[k] <= prod[k];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < lanes; k++) lane_sum = lane_sum + SUM_W'(s1_prod[k]);
    end

    assign cnt_inc = cnt + CNT_W'(1);
    assign close   = s1_last || (cnt_inc == CNT_W'(block_len));

`ifdef MX_DOT_ACC_SAT_EN
    localparam int FULL_W = ((acc_width > SUM_W) ? acc_width : SUM_W) + 1;
    localparam logic signed [FULL_W-1:0] SAT_MAX =
        {{(FULL_W-acc_width+1){1'b0}}, {(acc_width-1){1'b1}}};
    localparam logic signed [FULL_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [FULL_W-1:0] full_sum;
    logic                     sat_hit;
    logic                     sat_flag;

    always_comb begin
        full_sum = FULL_W'(acc) + FULL_W'(lane_sum);
        sat_hit  = 1'b0;
        acc_next = full_sum[acc_width-1:0];
        if (full_sum > SAT_MAX) begin
            acc_next = SAT_MAX[acc_width-1:0];
            sat_hit  = 1'b1;
        end else if (full_sum < SAT_MIN) begin
            acc_next = SAT_MIN[acc_width-1:0];
            sat_hit  = 1'b1;
        end
    end

    // Sticky saturation flag lives with the block and is reported alongside its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            o_ovf    <= 1'b0;
        end else if (beat_go) begin
            if (close) begin
                o_ovf    <= sat_flag | sat_hit;
                sat_flag <= 1'b0;
            end else begin
                sat_flag <= sat_flag | sat_hit;
            end
        end
    end
`else
    assign acc_next = acc + acc_width'(lane_sum);
    assign o_ovf    = 1'b0;
`endif

    // Stage 2: accumulate, and on a closing beat publish the result and start a fresh block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_acc   <= '0;
            o_len   <= '0;
        end else begin
            if (o_valid && i_out_ready) o_valid <= 1'b0;
            if (beat_go) begin
                if (close) begin
                    o_acc   <= acc_next;
                    o_len   <= cnt_inc;
                    o_valid <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_mx_dot_acc.sv
// Self-checking bench for mx_dot_acc: directed scenarios plus randomized traffic against a queue model.
// Runs a 32-bit and a 20-bit accumulator instance side by side on the same stimulus.
module tb_mx_dot_acc;
    localparam int EXP_W  = 3;
    localparam int MAN_W  = 2;
    localparam int LANES  = 4;
    localparam int BLEN   = 8;
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int NARROW = 20;

    logic clk = 1'b0;
    logic rst_n, i_valid, i_last, i_out_ready;
    logic [LANES*W-1:0] i_op0, i_op1;
    logic o_ready, o_valid, o_ovf, n_ready, n_valid, n_ovf;
    logic signed [31:0]       o_acc;
    logic signed [NARROW-1:0] n_acc;
    logic [3:0] o_len, n_len;

    mx_dot_acc #(.exp_width(EXP_W), .man_width(MAN_W), .lanes(LANES),
                 .block_len(BLEN), .acc_width(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op0(i_op0), .i_op1(i_op1), .i_last(i_last), .o_valid(o_valid),
        .i_out_ready(i_out_ready), .o_acc(o_acc), .o_len(o_len), .o_ovf(o_ovf));

    mx_dot_acc #(.exp_width(EXP_W), .man_width(MAN_W), .lanes(LANES),
                 .block_len(BLEN), .acc_width(NARROW)) u_narrow (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(n_ready),
        .i_op0(i_op0), .i_op1(i_op1), .i_last(i_last), .o_valid(n_valid),
        .i_out_ready(i_out_ready), .o_acc(n_acc), .o_len(n_len), .o_ovf(n_ovf));

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        int     len;
        bit     ovf;
        longint accn;
        bit     ovfn;
    } exp_t;

    int     checks = 0;
    int     failures = 0;
    exp_t   q[$];
    longint m_acc, m_accn;
    bit     m_ovf, m_ovfn;
    int     m_cnt;
    bit     prev_stall;
    longint held_acc;
    int     held_len;

    bit     s_valid, s_ready, s_ovf, sn_valid, sn_ovf;
    longint s_acc, sn_acc;
    int     s_len, sn_len;

    function automatic longint dec(input logic [W-1:0] x);
        int     e;
        int     m;
        longint mag;
        e = int'(x[W-2 -: EXP_W]);
        m = int'(x[MAN_W-1:0]);
        mag = (e == 0) ? longint'(m) : (longint'((1 << MAN_W) + m) << (e - 1));
        return x[W-1] ? -mag : mag;
    endfunction

    function automatic longint beat_sum(input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b);
        longint s = 0;
        for (int k = 0; k < LANES; k++) s += dec(a[k*W +: W]) * dec(b[k*W +: W]);
        return s;
    endfunction

    function automatic longint upd(input longint acc, input longint add, input int w, output bit sat);
        longint full, hi, lo, r;
        full = acc + add;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -hi - 1;
        sat  = 1'b0;
`ifdef MX_DOT_ACC_SAT_EN
        r = full;
        if (full > hi) begin r = hi; sat = 1'b1; end
        if (full < lo) begin r = lo; sat = 1'b1; end
`else
        r = full & ((longint'(1) << w) - 1);
        if (r > hi) r -= (longint'(1) << w);
`endif
        return r;
    endfunction

    task automatic model_clear();
        m_acc = 0; m_accn = 0; m_ovf = 0; m_ovfn = 0; m_cnt = 0;
    endtask

    task automatic model_accept();
        longint bs;
        bit     sat;
        exp_t   e;
        bs = beat_sum(i_op0, i_op1);
        m_acc  = upd(m_acc, bs, 32, sat);      m_ovf  |= sat;
        m_accn = upd(m_accn, bs, NARROW, sat); m_ovfn |= sat;
        m_cnt++;
        if (i_last || m_cnt == BLEN) begin
            e.acc = m_acc; e.len = m_cnt; e.ovf = m_ovf; e.accn = m_accn; e.ovfn = m_ovfn;
            q.push_back(e);
            model_clear();
        end
    endtask

    // Sample settled outputs just after a falling edge, update the scoreboard, then advance one cycle.
    task automatic tick();
        exp_t e;
        #1;
        s_valid = o_valid; s_ready = o_ready; s_acc = o_acc; s_len = int'(o_len); s_ovf = o_ovf;
        sn_valid = n_valid; sn_acc = n_acc; sn_len = int'(n_len); sn_ovf = n_ovf;
        checks++;
        if (!rst_n) begin
            if (s_valid || sn_valid || s_acc != 0 || s_len != 0 || s_ovf || !s_ready) begin
                failures++;
                $display("FAIL reset_state: valid=%0b acc=%0d len=%0d ovf=%0b ready=%0b, required 0/0/0/0/1",
                         s_valid, s_acc, s_len, s_ovf, s_ready);
            end
            q.delete();
            model_clear();
            prev_stall = 1'b0;
        end else begin
            if (s_ready !== !(s_valid && !i_out_ready) || sn_valid !== s_valid) begin
                failures++;
                $display("FAIL ready_rule: ready=%0b valid=%0b out_ready=%0b narrow_valid=%0b",
                         s_ready, s_valid, i_out_ready, sn_valid);
            end
            if (prev_stall) begin
                checks++;
                if (!s_valid || s_acc != held_acc || s_len != held_len) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b acc=%0d len=%0d, required 1/%0d/%0d",
                             s_valid, s_acc, s_len, held_acc, held_len);
                end
            end
            if (s_valid && i_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: acc=%0d len=%0d with no block pending", s_acc, s_len);
                end else begin
                    e = q.pop_front();
                    if (s_acc != e.acc || s_len != e.len || s_ovf != e.ovf ||
                        sn_acc != e.accn || sn_len != e.len || sn_ovf != e.ovfn) begin
                        failures++;
                        $display("FAIL result: acc=%0d len=%0d ovf=%0b n_acc=%0d n_len=%0d n_ovf=%0b, required %0d/%0d/%0b/%0d/%0d/%0b",
                                 s_acc, s_len, s_ovf, sn_acc, sn_len, sn_ovf,
                                 e.acc, e.len, e.ovf, e.accn, e.len, e.ovfn);
                    end
                end
            end
            if (i_valid && s_ready) model_accept();
            prev_stall = s_valid && !i_out_ready;
            held_acc   = s_acc;
            held_len   = s_len;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_all(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 0; k < LANES; k++) begin
            i_op0[k*W +: W] = a;
            i_op1[k*W +: W] = b;
        end
    endtask

    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit last);
        set_all(a, b);
        i_valid = 1'b1;
        i_last  = last;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_result(input int budget, input string name);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = s_valid;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout: no o_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (s_valid || s_acc != 0 || s_len != 0 || s_ovf || !s_ready || sn_acc != 0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b acc=%0d len=%0d ovf=%0b ready=%0b", s_valid, s_acc, s_len, s_ovf, s_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int b = 0; b < BLEN; b++) begin
            set_all(6'h05, 6'h01);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if (s_valid) begin
            failures++;
            $display("FAIL basic_early: o_valid=1 one cycle after the 8th accept, required 0");
        end
        tick();
        checks++;
        if (!s_valid || s_acc != 160 || s_len != 8) begin
            failures++;
            $display("FAIL basic_auto_close: valid=%0b acc=%0d len=%0d, required 1/160/8", s_valid, s_acc, s_len);
        end
        // i_last on the block_len-th beat must produce exactly one result.
        for (int b = 0; b < BLEN; b++) beat(6'h05, 6'h01, b == BLEN - 1);
        wait_result(4, "last_on_full");
        checks++;
        if (s_acc != 160 || s_len != 8) begin
            failures++;
            $display("FAIL last_on_full: acc=%0d len=%0d, required 160/8", s_acc, s_len);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_valid) begin
                failures++;
                $display("FAIL no_empty_block: o_valid=1 len=%0d after a full block closed by i_last", s_len);
            end
        end
    endtask

    task automatic test_max();
        longint exp_n;
        bit     exp_ovf;
`ifdef MX_DOT_ACC_SAT_EN
        exp_n = 524287;  exp_ovf = 1'b1;
`else
        exp_n = -245760; exp_ovf = 1'b0;
`endif
        beat(6'h1F, 6'h1F, 1'b1);
        wait_result(4, "max");
        checks++;
        if (s_acc != 802816 || s_len != 1 || s_ovf) begin
            failures++;
            $display("FAIL max_wide: acc=%0d len=%0d ovf=%0b, required 802816/1/0", s_acc, s_len, s_ovf);
        end
        checks++;
        if (sn_acc != exp_n || sn_ovf != exp_ovf) begin
            failures++;
            $display("FAIL max_narrow: acc=%0d ovf=%0b, required %0d/%0b", sn_acc, sn_ovf, exp_n, exp_ovf);
        end
    endtask

    task automatic test_signs();
        i_op0 = '0;
        i_op1 = '0;
        i_op0[W-1:0] = 6'h24;
        i_op1[W-1:0] = 6'h04;
        i_valid = 1'b1;
        i_last  = 1'b1;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        wait_result(4, "neg");
        checks++;
        if (s_acc != -16 || s_len != 1) begin
            failures++;
            $display("FAIL sign_neg: acc=%0d len=%0d, required -16/1", s_acc, s_len);
        end
        beat(6'h20, 6'h1F, 1'b1);
        wait_result(4, "negzero");
        checks++;
        if (s_acc != 0 || s_len != 1) begin
            failures++;
            $display("FAIL sign_negzero: acc=%0d len=%0d, required 0/1", s_acc, s_len);
        end
    endtask

    task automatic test_back_to_back();
        i_out_ready = 1'b0;
        beat(6'h05, 6'h01, 1'b1);
        beat(6'h05, 6'h02, 1'b1);
        tick();
        checks++;
        if (!s_valid || s_acc != 20 || s_ready) begin
            failures++;
            $display("FAIL bp_first: valid=%0b acc=%0d ready=%0b, required 1/20/0", s_valid, s_acc, s_ready);
        end
        for (int i = 0; i < 3; i++) tick();
        i_out_ready = 1'b1;
        tick();
        checks++;
        if (!s_valid || s_acc != 20) begin
            failures++;
            $display("FAIL bp_hold: valid=%0b acc=%0d, required 1/20", s_valid, s_acc);
        end
        tick();
        checks++;
        if (!s_valid || s_acc != 40 || s_len != 1) begin
            failures++;
            $display("FAIL bp_second: valid=%0b acc=%0d len=%0d, required 1/40/1", s_valid, s_acc, s_len);
        end
        tick();
        checks++;
        if (s_valid) begin
            failures++;
            $display("FAIL bp_drained: o_valid=1 acc=%0d after both results taken", s_acc);
        end
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 3; b++) beat(6'h05, 6'h01, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++;
        if (s_valid) begin
            failures++;
            $display("FAIL reset_mid_valid: o_valid=1 during reset, required 0");
        end
        rst_n = 1'b1;
        beat(6'h05, 6'h01, 1'b0);
        beat(6'h05, 6'h01, 1'b1);
        wait_result(4, "reset_mid");
        checks++;
        if (s_acc != 40 || s_len != 2) begin
            failures++;
            $display("FAIL reset_mid_result: acc=%0d len=%0d, required 40/2", s_acc, s_len);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            i_out_ready = ($urandom_range(0, 9) < 7);
            i_valid     = ($urandom_range(0, 3) != 0);
            i_last      = ($urandom_range(0, 5) == 0);
            i_op0       = (LANES*W)'($urandom);
            i_op1       = (LANES*W)'($urandom);
            tick();
        end
        i_out_ready = 1'b1;
        beat(6'h1F, 6'h1F, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (q.size() != 0 || m_cnt != 0) begin
            failures++;
            $display("FAIL random_drain: %0d results never delivered, partial count %0d", q.size(), m_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_out_ready = 1'b1;
        i_op0 = '0; i_op1 = '0;
        prev_stall = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_signs();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/mx_dot_acc.md
Name: mx_dot_acc

Overview:
- Pipelined, parametrised minifloat dot-product accumulator; successor to the single-pair combinational minifloat multiplier.
- Each beat accepts `lanes` element pairs, multiplies each pair exactly into fixed point, sums across lanes and accumulates across beats.
- Emits one exact integer result per block through a valid/ready handshake.
- Sits between MX element unpacking and the shared-scale application stage.

Parameters:
- exp_width, 3, element exponent field width.
- man_width, 2, element mantissa field width.
- lanes, 4, element pairs per beat (≥1).
- block_len, 8, beats after which a block closes automatically (≥1).
- acc_width, 32, signed accumulator/result width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept a beat.
- i_op0  input  lanes*(1+exp_width+man_width)  lane k at bits [k*W +: W], W=1+exp_width+man_width.
- i_op1  input  same as i_op0  second operand vector.
- i_last  input  1  beat closes the current block early.
- o_valid  output  1  result valid.
- i_out_ready  input  1  downstream accepts result.
- o_acc  output  acc_width  signed block sum.
- o_len  output  clog2(block_len+1)  beats in the reported block.
- o_ovf  output  1  result saturated (ACC_SAT_EN only; else tied 0).

Behaviour:
- Element format: sign-magnitude, fields {s, e, m}; no bias, no inf/NaN.
- Integer magnitude: e==0 → m; e>0 → {1,m} << (e-1). Sign s negates the magnitude; negative zero is 0.
- Lane product: exact signed product of the two element integers.
- Lane sum: exact, width prd_width+clog2(lanes), where prd_width = 2*((1<<exp_width)+man_width+2).
- Beat accepted on a rising edge with i_valid && o_ready.
- Stage 1 (edge N, the accepting edge): register lane products plus last flag.
- Stage 2 (edge N+1): lane sum added to the accumulator.
- Beat counter counts beats in the current block.
- Block closes when i_last=1 or when the counter reaches block_len, whichever comes first.
- On the closing beat at edge N+1:
  - o_acc loaded with accumulator+sum; o_len loaded with the beat count.
  - Accumulator and counter cleared; o_valid set.
  - Result visible in the cycle after edge N+1, i.e. 2 cycles after acceptance.
- Non-closing beats update the accumulator only.
- Stall = o_valid && !i_out_ready.
  - o_ready = !stall (combinational).
  - Under stall, both stage registers, accumulator and counter hold.
- o_valid clears on the edge where o_valid && i_out_ready, unless a new closing beat completes on the same edge; then it stays 1 and o_acc/o_len take the new values. No result is lost or duplicated.
- Default width handling (no macro): arithmetic wraps modulo 2^acc_width.
- Reset (asserted at any time, including mid-block):
  - o_valid=0, o_acc=0, o_len=0, o_ovf=0.
  - Pipeline valids, accumulator and counter cleared; partial block discarded.
  - o_ready=1 out of reset.
- i_last on the block_len-th beat closes once, with no empty block.

Optional Feature:
- Macro: MX_DOT_ACC_SAT_EN.
- Defined:
  - Accumulation saturates at the signed acc_width bounds, detected at full internal width each beat.
  - A sticky flag is set on any saturation within the block.
  - o_ovf loads with o_acc; the flag clears with the block.
- Undefined: wrap-around, and o_ovf tied 0.

Test Plan:
- E3M2, all lanes op0=0x05 (int 5), op1=0x01 (int 1), 8 beats, i_last=0, i_out_ready=1 → o_valid pulses 2 cycles after the 8th accept; o_acc=160, o_len=8.
- All lanes op0=op1=0x1F (int 448), single beat with i_last=1 → o_acc=802816, o_len=1.
- Signs, single beat with i_last=1:
  - lane0 0x24×0x04 → o_acc=-16, other lanes 0.
  - Separate block, all lanes 0x20×0x1F → o_acc=0.
- Backpressure: i_out_ready=0, send two 1-beat blocks (sums 20, 40) back-to-back.
  - o_ready drops after the first result.
  - 20 is held stable until the handshake; then 40 follows; no loss.
- Reset mid-block: 3 beats of sum 20, pull rst_n low for 1 cycle, then a 2-beat block of sum 20 per beat → o_valid low during reset; next result o_acc=40, o_len=2.
- acc_width=20, one beat all lanes 0x1F with i_last=1:
  - With MX_DOT_ACC_SAT_EN → o_acc=524287, o_ovf=1.
  - Without the macro → o_acc=-245760, o_ovf=0.
